hi_sniffer_stream: RTL
======================

HI_SNIFFER_STREAM -- requirements
Module: hi_sniffer_stream

Interface
REQ-001 Parameter SAMPLE_W, default 8: ADC sample width and serial data bits per frame.
REQ-002 Parameter DECIM_LOG2, default 4: decimation factor is 2^DECIM_LOG2; legal range 0..6.
REQ-003 Parameter FIFO_DEPTH, default 4: sample buffer entries; power of 2, at least 2.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high (ports ck_1356meg, rst).
REQ-005 ck_1356meg  in  1  system clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 enable  in  1  capture enable.
REQ-008 msb_first  in  1  bit order select: 1 = MSB first, 0 = LSB first.
REQ-009 adc_d  in  SAMPLE_W  ADC sample.
REQ-010 adc_clk  out  1  equal to ck_1356meg.
REQ-011 pwr_lo, pwr_hi, pwr_oe1..pwr_oe4  out  1 each  constant 0 (passive sniffing).
REQ-012 ssp_clk  out  1  equal to ~ck_1356meg.
REQ-013 ssp_frame  out  1  high on the first bit of each frame.
REQ-014 ssp_din  out  1  serial data bit.
REQ-015 overflow  out  1  sticky flag: a decimated sample was dropped.
REQ-016 fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-017 Decimator, each cycle with enable=1:
- accumulate adc_d into an accumulator of SAMPLE_W+DECIM_LOG2 bits;
- advance a counter modulo 2^DECIM_LOG2.
REQ-018 On the counter's terminal cycle:
- push (acc + adc_d) >> DECIM_LOG2 (truncation, no rounding);
- clear the accumulator and the counter on the same edge.
REQ-019 enable=0: accumulator and counter clear to 0; no pushes; frames in flight and buffered samples continue to drain.
REQ-020 FIFO full with no pop: the push is discarded and overflow sets; overflow clears only on rst.
REQ-021 FIFO full with simultaneous push and pop: both are accepted; fifo_level is unchanged; overflow is not set.
REQ-022 Serializer FSM states are IDLE and SHIFT; all outputs are registered.
REQ-023 IDLE with FIFO non-empty:
- pop one sample and register ssp_frame=1 and the first bit on the same edge;
- go to SHIFT with bit counter = 1.
REQ-024 SHIFT: drive one bit per cycle with ssp_frame=0. After the last bit (counter = FRAME_LEN-1):
- FIFO non-empty: pop and start the next frame on the next cycle (back-to-back, no gap);
- otherwise: go to IDLE.
REQ-025 msb_first is sampled at pop time; a change mid-frame does not affect the current frame.
REQ-026 In IDLE, ssp_frame=0 and ssp_din=0.
REQ-027 Latency: a sample pushed into an empty FIFO at edge N produces ssp_frame=1 at edge N+1.
REQ-028 FRAME_LEN = SAMPLE_W, or SAMPLE_W+1 when parity is enabled (REQ-032).

Reset
REQ-029 On rst=1:
- FSM goes to IDLE; FIFO empties; accumulator, decimation counter and bit counter clear;
- outputs: ssp_frame=0, ssp_din=0, overflow=0, fifo_level=0.
REQ-030 rst asserted mid-frame aborts the frame at that edge; the partial frame is not resumed.
REQ-031 rst has priority over simultaneous push and pop.

Configuration
REQ-032 Macro HI_SNIFFER_PARITY_EN defined:
- each frame carries one odd-parity bit after the SAMPLE_W data bits, regardless of bit order;
- odd parity: the frame's total count of ones is odd.
REQ-033 HI_SNIFFER_PARITY_EN undefined: frames carry data bits only; no parity logic is synthesised.

Structure
REQ-034 Package hi_sniffer_pkg holds:
- the FSM state encoding (IDLE, SHIFT);
- the FRAME_LEN derivation;
- the default parameter constants.
REQ-035 The FIFO is a sub-module hi_sample_fifo, parametrised by width and depth. It provides push, pop, full, empty and level, and clears synchronously on rst.

Verification
REQ-036 SAMPLE_W=8, DECIM_LOG2=4, adc_d held at 0xA5, msb_first=0:
- every 16 cycles one frame with bits 1,0,1,0,0,1,0,1;
- ssp_frame high for exactly one cycle per frame.
REQ-037 adc_d ramps 0..15 over one decimation window: the pushed sample is 0x07 (sum 120 >> 4).
REQ-038 DECIM_LOG2=0, FIFO_DEPTH=4, enable=1 continuously: overflow rises once the FIFO is full, and frames continue back-to-back with no gaps.
REQ-039 HI_SNIFFER_PARITY_EN defined, sample 0xA5: 9-bit frame; the 9th bit is 1.
REQ-040 rst pulsed during bit 3 of a frame: on the next cycle ssp_frame=0, ssp_din=0, fifo_level=0 and overflow=0; the first frame after release starts only after a new push.

Source files
------------

// File: rtl/hi_sniffer_pkg.sv
// Shared types and constants for the HI sniffer stream block.
// Define HI_SNIFFER_PARITY_EN to append one odd-parity bit to every serial frame.
package hi_sniffer_pkg;

    localparam int SAMPLE_W_DEF   = 8;
    localparam int DECIM_LOG2_DEF = 4;
    localparam int FIFO_DEPTH_DEF = 4;

`ifdef HI_SNIFFER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    function automatic int frame_len(input int sample_w);
        return sample_w + PARITY_BITS;
    endfunction

endpackage

// File: rtl/hi_sample_fifo.sv
// Small synchronous sample FIFO with first-word fall-through read data.
// Pop is ignored when empty; push is accepted when not full or when popping on the same edge.
module hi_sample_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0]   level_q;
    logic          do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == (PW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rd_q];
    assign level_o = level_q;

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/hi_sniffer_stream.sv
// Passive HF sniffer: decimates ADC samples, buffers them and streams them out as SSP frames.
// HI_SNIFFER_PARITY_EN adds an odd-parity bit after the data bits of each frame.
module hi_sniffer_stream
    import hi_sniffer_pkg::*;
#(
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int DECIM_LOG2 = DECIM_LOG2_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          ck_1356meg,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          msb_first,
    input  logic [SAMPLE_W-1:0]           adc_d,
    output logic                          adc_clk,
    output logic                          pwr_lo,
    output logic                          pwr_hi,
    output logic                          pwr_oe1,
    output logic                          pwr_oe2,
    output logic                          pwr_oe3,
    output logic                          pwr_oe4,
    output logic                          ssp_clk,
    output logic                          ssp_frame,
    output logic                          ssp_din,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int FRAME_LEN = frame_len(SAMPLE_W);
    localparam int AW        = SAMPLE_W + DECIM_LOG2;
    localparam int CW        = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int BCW       = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0]  DCNT_LAST = CW'((1 << DECIM_LOG2) - 1);
    localparam logic [BCW-1:0] BCNT_END  = BCW'(FRAME_LEN);

    assign adc_clk = ck_1356meg;
    assign ssp_clk = ~ck_1356meg;
    assign pwr_lo  = 1'b0;
    assign pwr_hi  = 1'b0;
    assign pwr_oe1 = 1'b0;
    assign pwr_oe2 = 1'b0;
    assign pwr_oe3 = 1'b0;
    assign pwr_oe4 = 1'b0;

    // Decimator: the terminal sample is added combinationally so the window closes on one edge.
    logic [AW-1:0]       acc_q, acc_d, sum;
    logic [CW-1:0]       dcnt_q, dcnt_d;
    logic                dec_last, push;
    logic [SAMPLE_W-1:0] push_data;

    assign sum       = acc_q + AW'(adc_d);
    assign dec_last  = (dcnt_q == DCNT_LAST);
    assign push      = enable && dec_last;
    assign push_data = SAMPLE_W'(sum >> DECIM_LOG2);

    always_comb begin
        acc_d  = '0;
        dcnt_d = '0;
        if (enable && !dec_last) begin
            acc_d  = sum;
            dcnt_d = dcnt_q + 1'b1;
        end
    end

    logic                            pop, fifo_full, fifo_empty;
    logic [SAMPLE_W-1:0]             fifo_dout;
    logic                            overflow_q, overflow_d;

    hi_sample_fifo #(
        .W     (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (ck_1356meg),
        .rst_i   (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (push_data),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign overflow_d = overflow_q | (push && fifo_full && !pop);
    assign overflow   = overflow_q;

    // Frame word is pre-ordered so the serializer always shifts out bit 0 first.
    logic [SAMPLE_W-1:0]  ord;
    logic [FRAME_LEN-1:0] word;

    always_comb begin
        ord = fifo_dout;
        if (msb_first) begin
            for (int i = 0; i < SAMPLE_W; i++) ord[i] = fifo_dout[SAMPLE_W-1-i];
        end
    end

`ifdef HI_SNIFFER_PARITY_EN
    assign word = {~^fifo_dout, ord};
`else
    assign word = ord;
`endif

    ser_state_e           state_q, state_d;
    logic [BCW-1:0]       bcnt_q, bcnt_d;
    logic [FRAME_LEN-1:0] sh_q, sh_d;
    logic                 frame_q, frame_d, din_q, din_d;

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        sh_d    = sh_q;
        frame_d = 1'b0;
        din_d   = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    frame_d = 1'b1;
                    din_d   = word[0];
                    sh_d    = word >> 1;
                    bcnt_d  = BCW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // bcnt_q counts bits already on the wire; at BCNT_END the last bit is showing.
                if (bcnt_q == BCNT_END) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        frame_d = 1'b1;
                        din_d   = word[0];
                        sh_d    = word >> 1;
                        bcnt_d  = BCW'(1);
                    end else begin
                        bcnt_d  = '0;
                        state_d = IDLE;
                    end
                end else begin
                    din_d  = sh_q[0];
                    sh_d   = sh_q >> 1;
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            acc_q      <= '0;
            dcnt_q     <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            bcnt_q     <= '0;
            sh_q       <= '0;
            frame_q    <= 1'b0;
            din_q      <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            dcnt_q     <= dcnt_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            sh_q       <= sh_d;
            frame_q    <= frame_d;
            din_q      <= din_d;
        end
    end

    assign ssp_frame = frame_q;
    assign ssp_din   = din_q;

endmodule
